mcp4921_dac: RTL and testbench



---
 rtl/dac_pkg.sv | 33 +++
 rtl/mcp4921_dac_if.sv | 13 +
 rtl/clk_div_tick.sv | 36 +++
 rtl/mcp4921_dac.sv | 156 +++++++++++++++
 tb/tb_mcp4921_dac.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the MCP4921 DAC transmitter.
package dac_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

   localparam int unsigned DAC_BITS   = 12;
   localparam int unsigned FRAME_BITS = 16;

   // Config bits of the MCP4921 write command
   localparam int unsigned AB_BIT   = 15;
   localparam int unsigned BUF_BIT  = 14;
   localparam int unsigned GA_BIT   = 13;
   localparam int unsigned SHDN_BIT = 12;

   // Half-period counts of the multi-half-period states
   localparam int unsigned SHIFT_HALVES = 32;
   localparam int unsigned GAP_HALVES   = 2;

   // Assemble a write to DAC A with the output enabled
   function automatic logic [FRAME_BITS-1:0] build_word(input logic                vref_buf,
                                                        input logic                gain_1x,
                                                        input logic [DAC_BITS-1:0] data12);
      logic [FRAME_BITS-1:0] w;
      w                 = '0;
      w[DAC_BITS-1:0]   = data12;
      w[AB_BIT]         = 1'b0;
      w[BUF_BIT]        = vref_buf;
      w[GA_BIT]         = gain_1x;
      w[SHDN_BIT]       = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/mcp4921_dac_if.sv
// Sample stream into the DAC transmitter (valid/ready handshake).
interface mcp4921_dac_if #(
   parameter int unsigned N = 10
) ();

   logic [N-1:0] sample_in;
   logic         sample_valid;
   logic         sample_ready;

   modport master (output sample_in, output sample_valid, input sample_ready);
   modport slave  (input sample_in, input sample_valid, output sample_ready);

endinterface

// File: rtl/clk_div_tick.sv
// Free-running divider: one-cycle tick every 2^SCLK_N enabled clk cycles.
module clk_div_tick #(
   parameter int unsigned SCLK_N = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic restart_i,
   output logic tick_o
);

   logic [SCLK_N-1:0] cnt_q, cnt_d;

   // Count while enabled; hold at zero otherwise so each run starts a full period
   always_comb begin
      cnt_d = '0;
      if (en_i && !restart_i) begin
         cnt_d = cnt_q + SCLK_N'(1);
      end
   end

   // Tick on the last count of each period
   always_comb begin
      tick_o = en_i && (cnt_q == '1);
   end

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mcp4921_dac.sv
// SPI write-only master for the MCP4921 12-bit DAC.
// Optional macro MCP4921_LDAC_EN: drive LDAC_n as a one-half-period low strobe in the
// second GAP half-period; otherwise LDAC_n is tied low.
module mcp4921_dac
   import dac_pkg::*;
#(
   parameter int unsigned N        = 10,
   parameter int unsigned SCLK_N   = 4,
   parameter bit          GAIN_1X  = 1'b1,
   parameter bit          VREF_BUF = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   mcp4921_dac_if.slave     s_if,
   output logic             SCLK,
   output logic             SDI,
   output logic             CS_n,
   output logic             LDAC_n,
   output logic             frame_done
);

   state_e                state_q, state_d;
   logic [4:0]            hp_q, hp_d;
   logic                  ready_q, ready_d;
   logic [FRAME_BITS-1:0] word_q, word_d;
   logic [DAC_BITS-1:0]   data12;
   logic [3:0]            bit_idx;
   logic                  tick;
   logic                  accept;

   assign accept            = ready_q && s_if.sample_valid;
   assign s_if.sample_ready = ready_q;

   // Fit the sample into 12 bits: keep the MSBs, pad short samples with zeros
   if (N >= DAC_BITS) begin : g_trunc
      assign data12 = s_if.sample_in[N-1 -: DAC_BITS];
   end else begin : g_pad
      assign data12 = {s_if.sample_in, {(DAC_BITS - N){1'b0}}};
   end

   clk_div_tick #(
      .SCLK_N (SCLK_N)
   ) u_div (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (state_q != IDLE),
      .restart_i (accept),
      .tick_o    (tick)
   );

   // State, half-period counter, handshake and word registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         hp_q    <= '0;
         ready_q <= 1'b0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         ready_q <= ready_d;
         word_q  <= word_d;
      end
   end

   // Next-state: one step per divider tick once a frame is running
   always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      ready_d = ready_q;
      word_d  = word_q;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               state_d = SETUP;
               ready_d = 1'b0;
               hp_d    = '0;
               word_d  = build_word(VREF_BUF, GAIN_1X, data12);
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT;
               hp_d    = '0;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (hp_q == 5'(SHIFT_HALVES - 1)) begin
                  state_d = HOLD;
                  hp_d    = '0;
               end else begin
                  hp_d = hp_q + 5'd1;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               state_d = GAP;
               hp_d    = '0;
            end
         end
         GAP: begin
            if (tick) begin
               if (hp_q == 5'(GAP_HALVES - 1)) begin
                  state_d = IDLE;
                  hp_d    = '0;
                  // Ready rises together with the return to IDLE
                  ready_d = 1'b1;
               end else begin
                  hp_d = hp_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pin outputs decoded from state; all idle-safe when CS_n is high
   always_comb begin
      // Odd SHIFT half-periods carry SCLK high; each bit spans a low/high pair
      bit_idx    = ~hp_q[4:1];
      SCLK       = 1'b0;
      SDI        = 1'b0;
      CS_n       = 1'b1;
      frame_done = 1'b0;
`ifdef MCP4921_LDAC_EN
      LDAC_n     = 1'b1;
`else
      LDAC_n     = 1'b0;
`endif
      case (state_q)
         SETUP: begin
            CS_n = 1'b0;
            SDI  = word_q[AB_BIT];
         end
         SHIFT: begin
            CS_n = 1'b0;
            SCLK = hp_q[0];
            SDI  = word_q[bit_idx];
         end
         HOLD: begin
            CS_n = 1'b0;
         end
         GAP: begin
            frame_done = tick && (hp_q == 5'(GAP_HALVES - 1));
`ifdef MCP4921_LDAC_EN
            LDAC_n     = !(hp_q == 5'(GAP_HALVES - 1));
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mcp4921_dac.sv
// Bench for mcp4921_dac: time-based frame model checked every cycle, plus directed checks.
// Honours MCP4921_LDAC_EN when defined for the build.
module tb_mcp4921_dac;

   localparam int HALF  = 16;   // clk cycles per SCLK half-period at SCLK_N=4
   localparam int FRAME = 36 * HALF;
`ifdef MCP4921_LDAC_EN
   localparam bit LdacIdle = 1'b1;
`else
   localparam bit LdacIdle = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mcp4921_dac_if #(.N(10)) sif ();
   mcp4921_dac_if #(.N(14)) if14 ();
   mcp4921_dac_if #(.N(8))  if8 ();

   logic sclk, sdi, cs_n, ldac_n, fdone;
   logic sclk14, sdi14, cs14, ldac14, fd14;
   logic sclk8, sdi8, cs8, ldac8, fd8;

   mcp4921_dac #(.N(10)) dut (
      .clk (clk), .reset_n (reset_n), .s_if (sif), .SCLK (sclk), .SDI (sdi), .CS_n (cs_n),
      .LDAC_n (ldac_n), .frame_done (fdone)
   );
   mcp4921_dac #(.N(14)) dut14 (
      .clk (clk), .reset_n (reset_n), .s_if (if14), .SCLK (sclk14), .SDI (sdi14),
      .CS_n (cs14), .LDAC_n (ldac14), .frame_done (fd14)
   );
   mcp4921_dac #(.N(8)) dut8 (
      .clk (clk), .reset_n (reset_n), .s_if (if8), .SCLK (sclk8), .SDI (sdi8),
      .CS_n (cs8), .LDAC_n (ldac8), .frame_done (fd8)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // Frame model: outputs follow from the cycle count since the accepting edge
   bit          busy  = 1'b0;
   bit          rdy_m = 1'b0;
   int          t     = 0;
   logic [15:0] w_m   = '0;

   always @(posedge clk) begin
      int hp;
      logic e_cs, e_sclk, e_sdi, e_fd, e_ldac;
      if (!reset_n) begin
         busy  = 1'b0;
         rdy_m = 1'b0;
         t     = 0;
      end else if (!busy) begin
         if (rdy_m && sif.sample_valid) begin
            busy  = 1'b1;
            rdy_m = 1'b0;
            t     = 0;
            // DAC A, unbuffered, 1x gain, active; 10-bit sample left-justified
            w_m   = {4'b0011, sif.sample_in, 2'b00};
         end else begin
            rdy_m = 1'b1;
         end
      end else begin
         t++;
         if (t == FRAME) begin
            busy  = 1'b0;
            rdy_m = 1'b1;
         end
      end
      #1;
      e_cs = 1'b1; e_sclk = 1'b0; e_sdi = 1'b0; e_fd = 1'b0; e_ldac = LdacIdle;
      if (busy) begin
         hp = t / HALF;   // 0 setup, 1..32 bit halves, 33 hold, 34..35 gap
         if (hp <= 33) e_cs = 1'b0;
         if (hp == 0) begin
            e_sdi = w_m[15];
         end else if (hp <= 32) begin
            e_sdi  = w_m[15 - (hp - 1) / 2];
            e_sclk = (hp % 2 == 0);
         end
         e_fd = (t == FRAME - 1);
`ifdef MCP4921_LDAC_EN
         if (hp == 35) e_ldac = 1'b0;
`endif
      end
      check("cyc_ready", sif.sample_ready, rdy_m);
      check("cyc_cs_n", cs_n, e_cs);
      check("cyc_sclk", sclk, e_sclk);
      check("cyc_sdi", sdi, e_sdi);
      check("cyc_frame_done", fdone, e_fd);
      check("cyc_ldac_n", ldac_n, e_ldac);
   end

   // Capture what the DAC would clock in on each SCLK rise
   logic [15:0] sh = '0, sh14 = '0, sh8 = '0, w14 = '0, w8 = '0;
   int          rises = 0, n14 = 0, n8 = 0, hi_cnt = 0, last_gap = 0;
   logic [15:0] words[$];
   int          rcounts[$];
   longint      t_csr = 0, t_lf = 0, ldac_w = 0, ldac_off = 0;

   always @(negedge cs_n) begin
      sh    <= '0;
      rises <= 0;
   end
   always @(posedge sclk) if (!cs_n) begin
      sh    <= {sh[14:0], sdi};
      rises <= rises + 1;
   end
   always @(posedge clk) if (fdone) begin
      words.push_back(sh);
      rcounts.push_back(rises);
   end
   always @(negedge clk) begin
      if (cs_n) begin
         hi_cnt <= hi_cnt + 1;
      end else if (hi_cnt != 0) begin
         last_gap <= hi_cnt;
         hi_cnt   <= 0;
      end
   end
   always @(posedge cs_n) t_csr <= $time;
   always @(negedge ldac_n) t_lf <= $time;
   always @(posedge ldac_n) begin
      ldac_w   <= $time - t_lf;
      ldac_off <= t_lf - t_csr;
   end

   always @(posedge sclk14) if (!cs14) sh14 <= {sh14[14:0], sdi14};
   always @(posedge sclk8) if (!cs8) sh8 <= {sh8[14:0], sdi8};
   always @(posedge clk) begin
      if (fd14) begin w14 <= sh14; n14 <= n14 + 1; end
      if (fd8)  begin w8  <= sh8;  n8  <= n8 + 1;  end
   end

   longint t_acc = 0;

   // Present a sample and hold it until the accepting edge
   task automatic send(input logic [9:0] s, input bit drop);
      bit ok = 1'b0;
      @(negedge clk);
      sif.sample_in    = s;
      sif.sample_valid = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         if (sif.sample_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         timeout("send_accept");
      end else begin
         @(posedge clk);
         t_acc = $time;
      end
      if (drop) begin
         @(negedge clk);
         sif.sample_valid = 1'b0;
      end
   endtask

   // Return the clk edge time at which sample_ready rose
   task automatic wait_ready(output longint tr);
      bit ok = 1'b0;
      tr = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (sif.sample_ready) begin
            ok = 1'b1;
            tr = $time - 5;
            break;
         end
      end
      if (!ok) timeout("wait_ready");
   endtask

   initial begin
      longint tr;
      bit     ok;
      reset_n           = 1'b0;
      sif.sample_in     = '0;
      sif.sample_valid  = 1'b0;
      if14.sample_in    = 14'h3FFF;
      if14.sample_valid = 1'b1;
      if8.sample_in     = 8'hAB;
      if8.sample_valid  = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_ready", sif.sample_ready, 1'b0);
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_sclk", sclk, 1'b0);
      check("rst_sdi", sdi, 1'b0);
      check("rst_frame_done", fdone, 1'b0);
      check("rst_ldac_n", ldac_n, LdacIdle);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", sif.sample_ready, 1'b1);

      // Full-scale single frame
      send(10'h3FF, 1'b1);
      wait_ready(tr);
      check("latency_clk", 32'((tr - t_acc) / 10), 32'd576);
      check("frames_after_1", words.size(), 1);
      check("word_3ff", words[0], 16'h3FFC);
      check("rises_3ff", rcounts[0], 16);
`ifdef MCP4921_LDAC_EN
      check("ldac_offset_clk", 32'(ldac_off / 10), 32'd16);
      check("ldac_width_clk", 32'(ldac_w / 10), 32'd16);
`endif

      // Back-to-back with valid held, then a stray valid pulse mid-frame
      send(10'h200, 1'b0);
      send(10'h001, 1'b1);
      repeat (100) @(negedge clk);
      sif.sample_in    = 10'h155;
      sif.sample_valid = 1'b1;
      repeat (4) @(negedge clk);
      sif.sample_valid = 1'b0;
      wait_ready(tr);
      check("frames_after_b2b", words.size(), 3);
      check("word_200", words[1], 16'h3800);
      check("word_001", words[2], 16'h3004);
      check("cs_gap_min", (last_gap >= 32), 1'b1);
      check("cs_gap_no_bubble", (last_gap <= 33), 1'b1);
      repeat (40) @(negedge clk);
      check("no_extra_frame", words.size(), 3);
      check("idle_cs_n", cs_n, 1'b1);

      // Reset in the middle of a frame
      send(10'h0F0, 1'b1);
      ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (rises == 8) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeout("eighth_rise");
      reset_n = 1'b0;
      #1;
      check("abort_cs_n", cs_n, 1'b1);
      check("abort_sclk", sclk, 1'b0);
      check("abort_sdi", sdi, 1'b0);
      check("abort_ldac_n", ldac_n, LdacIdle);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_abort", sif.sample_ready, 1'b1);
      check("aborted_not_counted", words.size(), 3);
      send(10'h2AA, 1'b1);
      wait_ready(tr);
      check("frames_after_abort", words.size(), 4);
      check("word_2aa", words[3], 16'h3AA8);
      check("rises_2aa", rcounts[3], 16);

      // Other sample widths
      check("n14_seen", (n14 > 0), 1'b1);
      check("word_n14", w14, 16'h3FFF);
      check("n8_seen", (n8 > 0), 1'b1);
      check("word_n8", w8, 16'h3AB0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
